// File: rtl/stepper_pkg.sv
// stepper_pkg: shared phase patterns, FSM states and direction codes for the stepper controller
package stepper_pkg;
  typedef enum logic [1:0] {IDLE, RUN, SETTLE} state_t;
  localparam logic DIR_REV = 1'b0;
  localparam logic DIR_FWD = 1'b1;
  localparam logic [15:0] PHASE_PATS = 16'b1000_0100_0010_0001;
  function automatic logic [3:0] phase_pat(input logic [1:0] idx);
    return PHASE_PATS[{idx, 2'b00} +: 4];
  endfunction
endpackage

// File: rtl/step_rate_timer.sv
// step_rate_timer: step period generator with linear accel/decel ramp driven by steps remaining
module step_rate_timer #(
  parameter int STEPS_W      = 16,
  parameter int PERIOD_START = 1_000_000,
  parameter int PERIOD_MIN   = 250_000,
  parameter int RAMP_DEC     = 50_000
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               load,
  input  logic               run,
  input  logic [STEPS_W-1:0] remaining,
  output logic               step_tick
);
  localparam int PW = $clog2(PERIOD_START + RAMP_DEC + 1);
  logic [PW-1:0] period, timer, inc, dec;
  logic [STEPS_W-1:0] accel_cnt, rem_next;
  always_comb begin
    step_tick = run && timer == period - PW'(1);
    rem_next = remaining - STEPS_W'(1);
    inc = period + PW'(RAMP_DEC) > PW'(PERIOD_START) ? PW'(PERIOD_START) : period + PW'(RAMP_DEC);
    dec = period > PW'(PERIOD_MIN + RAMP_DEC) ? period - PW'(RAMP_DEC) : PW'(PERIOD_MIN);
  end
  always_ff @(posedge clk) begin
    if (!rst || load) begin
      period <= PW'(PERIOD_START);
      timer <= '0;
      accel_cnt <= '0;
    end else if (step_tick) begin
      timer <= '0;
      if (rem_next != '0 && rem_next <= accel_cnt) begin
        period <= inc;
        accel_cnt <= accel_cnt - STEPS_W'(1);
      end else if (rem_next != '0 && period > PW'(PERIOD_MIN)) begin
        period <= dec;
        accel_cnt <= accel_cnt + STEPS_W'(1);
      end
    end else if (run) begin
      timer <= timer + PW'(1);
    end
  end
endmodule

// File: rtl/stepper_move_controller.sv
// stepper_move_controller: accepts move commands and sequences the 4-phase coil pattern with ramped step rate
module stepper_move_controller
  import stepper_pkg::*;
#(
  parameter int STEPS_W      = 16,
  parameter int POS_W        = 24,
  parameter int PERIOD_START = 1_000_000,
  parameter int PERIOD_MIN   = 250_000,
  parameter int RAMP_DEC     = 50_000
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic               cmd_dir,
  input  logic [STEPS_W-1:0] cmd_steps,
  input  logic               abort,
  input  logic               hold_en,
  output logic [3:0]         signal_out,
  output logic               busy,
  output logic               done,
  output logic               aborted,
  output logic [POS_W-1:0]   position
);
  localparam int SW = $clog2(PERIOD_START + 1);
  state_t state, state_n;
  logic dir, accept, step, finish, step_tick;
  logic [1:0] idx, idx_n;
  logic [STEPS_W-1:0] remaining;
  logic [SW-1:0] settle_cnt;
  step_rate_timer #(
    .STEPS_W(STEPS_W), .PERIOD_START(PERIOD_START), .PERIOD_MIN(PERIOD_MIN), .RAMP_DEC(RAMP_DEC)
  ) u_timer (
    .clk(clk), .rst(rst), .load(accept), .run(state == RUN),
    .remaining(remaining), .step_tick(step_tick)
  );
  always_ff @(posedge clk) begin
    if (!rst) state <= IDLE;
    else state <= state_n;
  end
  always_comb begin
    state_n = state;
    accept = 1'b0;
    step = 1'b0;
    case (state)
      IDLE: if (cmd_valid) begin
        accept = 1'b1;
        state_n = cmd_steps == '0 ? SETTLE : RUN;
      end
      RUN: if (abort) state_n = IDLE;
        else if (step_tick) begin
          step = 1'b1;
          state_n = remaining == STEPS_W'(1) ? SETTLE : RUN;
        end
      SETTLE: state_n = abort || settle_cnt == SW'(PERIOD_START - 1) ? IDLE : SETTLE;
      default: state_n = IDLE;
    endcase
    finish = state != IDLE && state_n == IDLE;
    idx_n = !step ? idx : dir == DIR_FWD ? idx + 2'd1 : idx - 2'd1;
    cmd_ready = state == IDLE;
    busy = state != IDLE;
  end
  // signal_out and position are computed from next-state values so they move on the step edge itself
  always_ff @(posedge clk) begin
    if (!rst) begin
      idx <= '0;
      position <= '0;
      signal_out <= '0;
      done <= 1'b0;
      aborted <= 1'b0;
      dir <= 1'b0;
      remaining <= '0;
      settle_cnt <= '0;
    end else begin
      idx <= idx_n;
      done <= finish;
      signal_out <= state_n != IDLE || hold_en ? phase_pat(idx_n) : 4'b0000;
      settle_cnt <= state == SETTLE ? settle_cnt + SW'(1) : '0;
      if (accept) begin
        dir <= cmd_dir;
        remaining <= cmd_steps;
        aborted <= 1'b0;
      end
      if (abort && state != IDLE) aborted <= 1'b1;
      if (step) begin
        remaining <= remaining - STEPS_W'(1);
        position <= dir == DIR_REV ? position - POS_W'(1) : position + POS_W'(1);
      end
    end
  end
endmodule

// File: tb/tb_stepper_move_controller.sv
// tb_stepper_move_controller: directed and random moves checked against a step-level profile model
module tb_stepper_move_controller;
  localparam int PS = 8, PM = 4, RD = 2;
  typedef int iq_t[$];
  logic clk = 1'b0, rst = 1'b0, cmd_valid = 1'b0, cmd_dir = 1'b0, abort = 1'b0, hold_en = 1'b0;
  logic [15:0] cmd_steps = '0;
  logic cmd_ready, busy, done, aborted;
  logic [3:0] signal_out, last_sig = 4'b0000;
  logic [23:0] position, pos_m = '0;
  int edge_n = 0, total = 0, bad = 0, midx = 0;
  int chg_e[$], done_e[$];
  logic [3:0] chg_p[$];
  stepper_move_controller #(
    .STEPS_W(16), .POS_W(24), .PERIOD_START(PS), .PERIOD_MIN(PM), .RAMP_DEC(RD)
  ) dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_dir(cmd_dir),
    .cmd_steps(cmd_steps), .abort(abort), .hold_en(hold_en), .signal_out(signal_out),
    .busy(busy), .done(done), .aborted(aborted), .position(position)
  );
  always #5 clk = ~clk;
  always @(posedge clk) edge_n <= edge_n + 1;
  always @(negedge clk) begin
    if (signal_out !== last_sig) begin
      chg_e.push_back(edge_n);
      chg_p.push_back(signal_out);
    end
    last_sig = signal_out;
    if (done === 1'b1) done_e.push_back(edge_n);
  end
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic step_neg();
    @(negedge clk);
    #1;
  endtask
  function automatic iq_t model_gaps(input int n);
    iq_t q;
    int p = PS, a = 0;
    for (int i = 1; i <= n; i++) begin
      q.push_back(p);
      if (n - i != 0 && n - i <= a) begin
        p = p + RD > PS ? PS : p + RD;
        a--;
      end else if (n - i != 0 && p > PM) begin
        p = p - RD < PM ? PM : p - RD;
        a++;
      end
    end
    return q;
  endfunction
  function automatic logic [3:0] pat(input int i);
    return 4'(1 << i);
  endfunction
  task automatic clear_logs();
    chg_e.delete();
    chg_p.delete();
    done_e.delete();
  endtask
  task automatic start_cmd(input logic d, input int n, output int acc);
    cmd_dir = d;
    cmd_steps = 16'(n);
    cmd_valid = 1'b1;
    chk("ready_before_accept", 32'(cmd_ready), 1);
    step_neg();
    acc = edge_n;
    chk("busy_after_accept", 32'(busy), 1);
    chk("ready_after_accept", 32'(cmd_ready), 0);
  endtask
  task automatic wait_done(input int need);
    int w = 0;
    while (done_e.size() < need && w < 400) begin
      step_neg();
      w++;
    end
    chk("done_within_budget", 32'(done_e.size() >= need), 1);
  endtask
  task automatic check_move(input string tag, input logic d, input int n, input int acc, input int di);
    iq_t g = model_gaps(n);
    int e = acc;
    chk({tag, "_changes"}, 32'(chg_e.size()), 32'(n));
    for (int i = 0; i < n; i++) begin
      e += g[i];
      midx = d ? (midx + 1) % 4 : (midx + 3) % 4;
      pos_m = d ? pos_m + 24'd1 : pos_m - 24'd1;
      if (i < chg_e.size()) begin
        chk({tag, "_edge"}, 32'(chg_e[i]), 32'(e));
        chk({tag, "_pat"}, 32'(chg_p[i]), 32'(pat(midx)));
      end
    end
    chk({tag, "_done_edge"}, 32'(done_e[di]), 32'(e + PS));
  endtask
  task automatic run_move(input string tag, input logic d, input int n);
    int acc;
    clear_logs();
    start_cmd(d, n, acc);
    cmd_valid = 1'b0;
    wait_done(1);
    if (done_e.size() > 0) check_move(tag, d, n, acc, 0);
    chk({tag, "_pos"}, 32'(position), 32'(pos_m));
    chk({tag, "_busy_end"}, 32'(busy), 0);
    chk({tag, "_ready_end"}, 32'(cmd_ready), 1);
    chk({tag, "_aborted_end"}, 32'(aborted), 0);
    step_neg();
    chk({tag, "_done_pulse"}, 32'(done), 0);
  endtask
  initial begin
    int acc, w;
    step_neg();
    step_neg();
    rst = 1'b1;
    chk("rst_sig", 32'(signal_out), 0);
    chk("rst_pos", 32'(position), 0);
    chk("rst_ready", 32'(cmd_ready), 1);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    step_neg();
    chk("hold_off_sig", 32'(signal_out), 0);
    hold_en = 1'b1;
    step_neg();
    chk("hold_on_sig", 32'(signal_out), 32'(4'b0001));
    run_move("fwd6", 1'b1, 6);
    run_move("rev3", 1'b0, 3);
    clear_logs();
    start_cmd(1'b1, 10, acc);
    cmd_valid = 1'b0;
    w = 0;
    while (chg_e.size() < 2 && w < 200) begin
      step_neg();
      w++;
    end
    chk("abort_two_steps", 32'(chg_e.size()), 2);
    step_neg();
    step_neg();
    abort = 1'b1;
    step_neg();
    abort = 1'b0;
    midx = (midx + 2) % 4;
    pos_m = pos_m + 24'd2;
    chk("abort_done", 32'(done), 1);
    chk("abort_flag", 32'(aborted), 1);
    chk("abort_ready", 32'(cmd_ready), 1);
    chk("abort_pos", 32'(position), 32'(pos_m));
    repeat (20) step_neg();
    chk("abort_no_more_steps", 32'(chg_e.size()), 2);
    chk("abort_sig_kept", 32'(signal_out), 32'(pat(midx)));
    chk("abort_flag_holds", 32'(aborted), 1);
    run_move("zero", 1'b1, 0);
    clear_logs();
    start_cmd(1'b1, 3, acc);
    wait_done(1);
    if (done_e.size() > 0) check_move("held_first", 1'b1, 3, acc, 0);
    chk("held_ready_at_done", 32'(cmd_ready), 1);
    step_neg();
    acc = edge_n;
    cmd_valid = 1'b0;
    chk("held_reaccepted", 32'(busy), 1);
    chk("held_single_done", 32'(done_e.size()), 1);
    chg_e.delete();
    chg_p.delete();
    wait_done(2);
    if (done_e.size() > 1) check_move("held_second", 1'b1, 3, acc, 1);
    chk("held_pos", 32'(position), 32'(pos_m));
    step_neg();
    for (int k = 0; k < 5; k++) run_move("rand", 1'($urandom_range(0, 1)), int'($urandom_range(0, 12)));
    clear_logs();
    start_cmd(1'b1, 10, acc);
    cmd_valid = 1'b0;
    repeat (15) step_neg();
    rst = 1'b0;
    step_neg();
    chk("midrst_sig", 32'(signal_out), 0);
    chk("midrst_pos", 32'(position), 0);
    chk("midrst_busy", 32'(busy), 0);
    chk("midrst_done", 32'(done), 0);
    chk("midrst_aborted", 32'(aborted), 0);
    chk("midrst_ready", 32'(cmd_ready), 1);
    rst = 1'b1;
    midx = 0;
    pos_m = '0;
    step_neg();
    run_move("post_rst", 1'b0, 4);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/stepper_move_controller.md
# stepper_move_controller

Sequences the 4-phase stepper coil driver for complete moves. Accepts a move command (direction plus step count) over a valid/ready handshake and produces the coil pattern with a symmetric linear accel/decel step-rate profile. Tracks absolute position and reports completion. It sits between the motion command logic and the PMOD stepper output pins, and replaces the free-running divided-clock drive.

## Interface
- `STEPS_W`, 16: width of the step-count field.
- `POS_W`, 24: width of the position counter.
- `PERIOD_START`, 1_000_000: clocks per step at start and end of a move; must be ≥ `PERIOD_MIN`.
- `PERIOD_MIN`, 250_000: clocks per step at cruise; must be ≥ 2.
- `RAMP_DEC`, 50_000: period change per step while ramping.
- `clk`  in  1  system clock; all logic on the rising edge.
- `rst`  in  1  synchronous reset, active-low.
- `cmd_valid`  in  1  a move command is presented.
- `cmd_ready`  out  1  the controller can accept a command; high only in IDLE.
- `cmd_dir`  in  1  1 = forward (+1 per step), 0 = reverse.
- `cmd_steps`  in  `STEPS_W`  number of steps in the move.
- `abort`  in  1  stops the move in progress.
- `hold_en`  in  1  keeps the coils energized while idle.
- `signal_out`  out  4  coil pattern, registered.
- `busy`  out  1  a move is in progress.
- `done`  out  1  one-cycle pulse when a move ends, including after an abort.
- `aborted`  out  1  set together with `done` when the move ended by `abort`; holds until the next accept.
- `position`  out  `POS_W`  signed absolute step count; wraps modulo 2^`POS_W`.

## Operation
- Reset values (applied when `rst` is low at a clock edge): state IDLE, phase index 0, `position` 0, `signal_out` 4'b0000, `busy` 0, `done` 0, `aborted` 0. After reset, `cmd_ready` is 1.
- Phase patterns: index 0/1/2/3 = 4'b0001 / 0010 / 0100 / 1000.
  - Forward: index +1 mod 4, `position` +1.
  - Reverse: index −1 mod 4, `position` −1.
- `signal_out` = pattern[index] when `busy` or `hold_en` is high, else 4'b0000. It is registered, so it follows a `hold_en` change one cycle later.
- States: IDLE, RUN, SETTLE.
  - IDLE → RUN when a command is accepted. On accept: latch `cmd_dir`; remaining = `cmd_steps`; period = `PERIOD_START`; timer = 0; accel_cnt = 0; clear `aborted`.
  - A command with `cmd_steps` = 0 goes IDLE → SETTLE and takes no step.
- In RUN, the timer counts up. When timer = period−1, the controller takes one step, resets the timer, decrements remaining, then applies the first matching rule:
  - remaining = 0 → SETTLE.
  - remaining ≤ accel_cnt → decelerate: period = min(`PERIOD_START`, period+`RAMP_DEC`), accel_cnt −1.
  - period > `PERIOD_MIN` → accelerate: period = max(`PERIOD_MIN`, period−`RAMP_DEC`), accel_cnt +1.
  - otherwise → cruise; period unchanged.
- SETTLE waits `PERIOD_START` clocks, then returns to IDLE with `done` pulsed.
- `abort` in RUN or SETTLE: next edge goes to IDLE with `done` = 1 and `aborted` = 1. No further step is taken, and the phase index is kept. `abort` in IDLE has no effect; a command presented in the same cycle is still accepted.
- `cmd_valid` outside IDLE is ignored and not queued.
- Period arithmetic is unsigned and at least `$clog2(PERIOD_START+1)` bits wide. The decelerate addition must not overflow before the clamp.

## Timing
- Accept edge = the edge at which `cmd_valid` and `cmd_ready` are both high. At that edge `busy` rises and `cmd_ready` falls.
- The first `signal_out` change is at accept + `PERIOD_START` edges. Each later change follows the previous one by the period then in force.
- `done`, `busy` falling and `cmd_ready` rising all happen on the same edge, `PERIOD_START` edges after the final step.
- A new command can be accepted on the edge after `done`.
- `position` updates on the same edge as `signal_out`.

## Structure
- Shared package/header `stepper_pkg`: phase pattern constants, state encoding, direction constants.
- One sub-module, `step_rate_timer`. It holds the period register, timer, accel_cnt and the ramp rules. Interface: load/start in; remaining in; `step_tick` out. The top level holds the FSM, handshake, phase index and position.

## Test plan
Bench parameters: `PERIOD_START`=8, `PERIOD_MIN`=4, `RAMP_DEC`=2.
- Reset with `hold_en`=0, then `hold_en`=1 → `signal_out` 0000, `position` 0, `cmd_ready` 1; after `hold_en`=1, `signal_out` = 0001 on the next edge.
- Forward move of 6 steps → gaps between coil changes 8,6,4,4,6,8; patterns 0010,0100,1000,0001,0010,0100; `position` 6; `done` 8 clocks after the sixth step.
- Reverse move of 3 steps from `position` 6 → gaps 8,6,8 (accel once, then decel); patterns 0010,0001,1000; `position` 3.
- `abort` two clocks after the second step of a 10-step move → `done` and `aborted` next edge, `position` +2, no further coil change, `cmd_ready` 1.
- `cmd_steps`=0 → no coil change, `done` 8 clocks after accept, `position` unchanged.
- `rst` low mid-move → next edge all outputs at reset values. `cmd_valid` held high during RUN → no second move until IDLE, then accepted once.
